scpu_ctrl: RTL and testbench
============================

SCPU_CTRL -- requirements
Module: scpu_ctrl

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 OPcode  input  6  instruction bits [31:26].
REQ-005 Fun  input  6  instruction function field, bits [5:0].
REQ-006 MIO_ready  input  1  memory/IO ready handshake from the bus.
REQ-007 RegDst  output  1  1 selects rd as the write register; 0 selects rt.
REQ-008 ALUSrc_B  output  1  1 selects the sign-extended immediate as ALU operand B.
REQ-009 MemtoReg  output  1  1 selects memory data for register write-back.
REQ-010 Jump  output  1  J-type jump.
REQ-011 Branch  output  1  beq branch.
REQ-012 RegWrite  output  1  register file write enable.
REQ-013 mem_w  output  1  data memory write enable.
REQ-014 ALUop  output  2  ALU operation class.
REQ-015 ALU_Control  output  3  ALU operation select.
REQ-016 CPU_MIO  output  1  memory/IO access request.
REQ-017 stall  output  1  1 holds the CPU PC while a memory access waits for MIO_ready.

Function
REQ-018 Decode outputs (RegDst through ALU_Control) SHALL be purely combinational from OPcode and Fun, and SHALL NOT depend on clk, rst_n or MIO_ready.
REQ-019 OPcode 000000 (R-type) SHALL give ALUop=10, RegDst=1, RegWrite=1; all other decode bits 0.
REQ-020 OPcode 100011 (lw) SHALL give ALUop=00, ALUSrc_B=1, MemtoReg=1, RegWrite=1, RegDst=0, CPU_MIO=1.
REQ-021 OPcode 101011 (sw) SHALL give ALUop=00, ALUSrc_B=1, mem_w=1, RegWrite=0, CPU_MIO=1.
REQ-022 OPcode 000100 (beq) SHALL give ALUop=01, Branch=1; all other decode bits 0.
REQ-023 OPcode 000010 (j) SHALL give Jump=1, ALUop=00; all other decode bits 0.
REQ-024 OPcode 100100 (0x24, slti) SHALL give ALUop=11, ALUSrc_B=1, RegWrite=1, RegDst=0.
REQ-025 Any other OPcode SHALL drive all 1-bit decode outputs to 0 and ALUop to 00.
REQ-026 ALUop=00 SHALL give ALU_Control=010; 01 SHALL give 110; 11 SHALL give 111.
REQ-027 ALUop=10 SHALL decode Fun: 100000->010 (add), 100010->110 (sub), 100100->000 (and), 100101->001 (or), 101010->111 (slt), 100111->100 (nor), 000010->101 (srl), 010110 or 100110->011 (xor); any other Fun->010.
REQ-028 The handshake FSM SHALL have two states, IDLE and WAIT.
REQ-029 In IDLE, the FSM SHALL go to WAIT on a clock edge when CPU_MIO=1 and MIO_ready=0, and SHALL otherwise stay in IDLE.
REQ-030 In WAIT, the FSM SHALL return to IDLE on a clock edge when MIO_ready=1, and SHALL otherwise stay in WAIT.
REQ-031 stall SHALL equal CPU_MIO AND NOT MIO_ready (combinational) in IDLE, SHALL equal NOT MIO_ready in WAIT, and SHALL be 0 whenever rst_n=0.
REQ-032 If OPcode changes to a non-memory instruction while in WAIT, the FSM SHALL remain in WAIT until MIO_ready=1.

Reset
REQ-033 rst_n=0 SHALL immediately force the FSM to IDLE and stall to 0, without waiting for a clock edge.
REQ-034 Decode outputs SHALL remain valid during reset.
REQ-035 On rst_n deassertion, the FSM SHALL leave IDLE no earlier than the first rising clk edge.

Verification
REQ-036 Bench: OPcode=0 with Fun sweep 100000/100010/100100/100101/101010/100111/000010/010110 -> ALU_Control 010/110/000/001/111/100/101/011, each with ALUop=10, RegDst=1, RegWrite=1.
REQ-037 Bench: OPcode=0, Fun=111111 -> ALU_Control=010.
REQ-038 Bench: OPcode 100011 then 101011 with MIO_ready=0 -> lw: ALUSrc_B=1, MemtoReg=1, RegWrite=1, stall=1; sw: mem_w=1, RegWrite=0.
REQ-039 Bench: OPcode 000100 -> Branch=1, ALUop=01, ALU_Control=110; OPcode 000010 -> Jump=1; OPcode 0x24 -> ALUop=11, ALUSrc_B=1, RegWrite=1, ALU_Control=111; OPcode 0x3F -> all decode outputs 0.
REQ-040 Bench: hold lw with MIO_ready=0 for 3 cycles -> FSM in WAIT, stall=1; raise MIO_ready -> stall=0 immediately and IDLE after the next edge.
REQ-041 Bench: assert rst_n=0 while in WAIT, between clock edges -> stall=0 at once and FSM in IDLE.

Source files
------------

// File: rtl/scpu_ctrl.sv
// Single-cycle CPU control unit: combinational instruction decode plus a
// two-state memory/IO handshake FSM that stalls the PC until MIO_ready.
module scpu_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OPcode,
  input  logic [5:0] Fun,
  input  logic       MIO_ready,
  output logic       RegDst,
  output logic       ALUSrc_B,
  output logic       MemtoReg,
  output logic       Jump,
  output logic       Branch,
  output logic       RegWrite,
  output logic       mem_w,
  output logic [1:0] ALUop,
  output logic [2:0] ALU_Control,
  output logic       CPU_MIO,
  output logic       stall
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_LW    = 6'b100011,
    OP_SLTI  = 6'b100100,
    OP_SW    = 6'b101011
  } opcode_t;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10,
    ALUOP_SLT  = 2'b11
  } aluop_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  always_comb begin
    RegDst   = 1'b0;
    ALUSrc_B = 1'b0;
    MemtoReg = 1'b0;
    Jump     = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    mem_w    = 1'b0;
    CPU_MIO  = 1'b0;
    ALUop    = ALUOP_ADD;
    case (OPcode)
      OP_RTYPE: begin
        ALUop    = ALUOP_FUNC;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      OP_LW: begin
        ALUSrc_B = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        CPU_MIO  = 1'b1;
      end
      OP_SW: begin
        ALUSrc_B = 1'b1;
        mem_w    = 1'b1;
        CPU_MIO  = 1'b1;
      end
      OP_BEQ: begin
        ALUop  = ALUOP_SUB;
        Branch = 1'b1;
      end
      OP_J: begin
        Jump = 1'b1;
      end
      OP_SLTI: begin
        ALUop    = ALUOP_SLT;
        ALUSrc_B = 1'b1;
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALU_Control = 3'b010;
    case (ALUop)
      ALUOP_ADD: ALU_Control = 3'b010;
      ALUOP_SUB: ALU_Control = 3'b110;
      ALUOP_SLT: ALU_Control = 3'b111;
      ALUOP_FUNC: begin
        case (Fun)
          6'b100000: ALU_Control = 3'b010;
          6'b100010: ALU_Control = 3'b110;
          6'b100100: ALU_Control = 3'b000;
          6'b100101: ALU_Control = 3'b001;
          6'b101010: ALU_Control = 3'b111;
          6'b100111: ALU_Control = 3'b100;
          6'b000010: ALU_Control = 3'b101;
          6'b010110,
          6'b100110: ALU_Control = 3'b011;
          default:   ALU_Control = 3'b010;
        endcase
      end
      default: ALU_Control = 3'b010;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (CPU_MIO && !MIO_ready) state_d = WAIT;
      WAIT:    if (MIO_ready)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Once waiting, the stall ignores CPU_MIO so an opcode change cannot drop it.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      if (state_q == WAIT) stall = !MIO_ready;
      else                 stall = CPU_MIO && !MIO_ready;
    end
  end

endmodule

// File: tb/tb_scpu_ctrl.sv
// Scoreboard bench for scpu_ctrl: expected decode/stall values are queued at
// drive time and popped when the DUT outputs are sampled.
module tb_scpu_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OPcode;
  logic [5:0] Fun;
  logic       MIO_ready;
  logic       RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite, mem_w;
  logic [1:0] ALUop;
  logic [2:0] ALU_Control;
  logic       CPU_MIO, stall;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    string       tag;
    logic [12:0] dec;
    logic        stall;
  } exp_t;

  exp_t sb[$];

  scpu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .OPcode     (OPcode),
    .Fun        (Fun),
    .MIO_ready  (MIO_ready),
    .RegDst     (RegDst),
    .ALUSrc_B   (ALUSrc_B),
    .MemtoReg   (MemtoReg),
    .Jump       (Jump),
    .Branch     (Branch),
    .RegWrite   (RegWrite),
    .mem_w      (mem_w),
    .ALUop      (ALUop),
    .ALU_Control(ALU_Control),
    .CPU_MIO    (CPU_MIO),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Packed decode vector: {RegDst,ALUSrc_B,MemtoReg,Jump,Branch,RegWrite,mem_w,ALUop,ALU_Control,CPU_MIO}
  function automatic logic [12:0] dec(input logic rd, input logic as, input logic m2r,
                                      input logic jmp, input logic br, input logic rw,
                                      input logic mw, input logic [1:0] aop,
                                      input logic [2:0] actl, input logic mio);
    return {rd, as, m2r, jmp, br, rw, mw, aop, actl, mio};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // sync=1: drive just after a falling edge; sync=0: drive now (mid-cycle).
  task automatic step(input string tag, input bit sync, input logic [5:0] op,
                      input logic [5:0] fn, input logic rdy,
                      input logic [12:0] dexp, input logic sexp);
    exp_t e;
    if (sync) @(negedge clk);
    OPcode    = op;
    Fun       = fn;
    MIO_ready = rdy;
    sb.push_back('{tag: tag, dec: dexp, stall: sexp});
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".dec"}, 32'({RegDst, ALUSrc_B, MemtoReg, Jump, Branch, RegWrite,
                                   mem_w, ALUop, ALU_Control, CPU_MIO}), 32'(e.dec));
    check_eq({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
  endtask

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] SLTI = 6'b100100;
  localparam logic [5:0] ADDF = 6'b100000;

  logic [5:0] funs [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b100111, 6'b000010, 6'b010110};
  logic [2:0] ctls [8] = '{3'b010, 3'b110, 3'b000, 3'b001,
                           3'b111, 3'b100, 3'b101, 3'b011};

  logic [12:0] D_LW, D_SW, D_BEQ, D_J, D_SLTI, D_NONE;

  initial begin
    D_LW   = dec(0, 1, 1, 0, 0, 1, 0, 2'b00, 3'b010, 1);
    D_SW   = dec(0, 1, 0, 0, 0, 0, 1, 2'b00, 3'b010, 1);
    D_BEQ  = dec(0, 0, 0, 0, 1, 0, 0, 2'b01, 3'b110, 0);
    D_J    = dec(0, 0, 0, 1, 0, 0, 0, 2'b00, 3'b010, 0);
    D_SLTI = dec(0, 1, 0, 0, 0, 1, 0, 2'b11, 3'b111, 0);
    D_NONE = dec(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0);

    rst_n = 1'b0; OPcode = '0; Fun = ADDF; MIO_ready = 1'b0;

    step("rst_rtype", 1, 6'b000000, ADDF, 0, dec(1, 0, 0, 0, 0, 1, 0, 2'b10, 3'b010, 0), 0);
    step("rst_lw",    1, LW, ADDF, 0, D_LW, 0);

    @(negedge clk); rst_n = 1'b1;
    step("post_rst",  0, 6'b000000, ADDF, 0, dec(1, 0, 0, 0, 0, 1, 0, 2'b10, 3'b010, 0), 0);

    for (int i = 0; i < 8; i++)
      step($sformatf("rtype_fun%0d", i), 1, 6'b000000, funs[i], 0,
           dec(1, 0, 0, 0, 0, 1, 0, 2'b10, ctls[i], 0), 0);
    step("rtype_fun3f", 1, 6'b000000, 6'b111111, 0, dec(1, 0, 0, 0, 0, 1, 0, 2'b10, 3'b010, 0), 0);

    step("lw_notready", 1, LW, ADDF, 0, D_LW, 1);
    step("sw_notready", 1, SW, ADDF, 0, D_SW, 1);
    step("beq",         1, BEQ, ADDF, 1, D_BEQ, 0);
    step("jump",        1, JMP, ADDF, 1, D_J, 0);
    step("slti",        1, SLTI, ADDF, 1, D_SLTI, 0);
    step("op3f",        1, 6'h3F, ADDF, 1, D_NONE, 0);

    step("wait_enter",  1, LW, ADDF, 0, D_LW, 1);
    for (int i = 0; i < 3; i++)
      step($sformatf("wait_hold%0d", i), 1, LW, ADDF, 0, D_LW, 1);
    step("wait_opchg",  0, BEQ, ADDF, 0, D_BEQ, 1);
    step("wait_opchg2", 1, BEQ, ADDF, 0, D_BEQ, 1);
    step("ready_imm",   0, BEQ, ADDF, 1, D_BEQ, 0);
    step("idle_after",  1, BEQ, ADDF, 0, D_BEQ, 0);

    step("rwait_enter", 1, LW, ADDF, 0, D_LW, 1);
    step("rwait_in",    1, BEQ, ADDF, 0, D_BEQ, 1);
    rst_n = 1'b0;
    step("rst_async",   0, BEQ, ADDF, 0, D_BEQ, 0);
    step("rst_lw_hold", 0, LW, ADDF, 0, D_LW, 0);
    @(negedge clk); rst_n = 1'b1;
    step("rst_idle",    0, BEQ, ADDF, 0, D_BEQ, 0);
    step("rst_rel_lw",  0, LW, ADDF, 0, D_LW, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
